button_conditioner: RTL



---
 rtl/game_pkg.sv | 15 +
 rtl/bit_synchronizer.sv | 24 ++
 rtl/button_conditioner.sv | 122 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and timing constants for the reaction-timer game.
package game_pkg;

  localparam int unsigned CLK_HZ        = 10_000_000;
  localparam int unsigned DEBOUNCE_1MS  = 10_000;
  localparam int unsigned LONG_PRESS_2S = 20_000_000;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } btn_state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit; flops reset to RESET_VAL.
module bit_synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces the raw game button; emits press/release/long-press strobes.
module button_conditioner
  import game_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_1MS,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_2S,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic busy
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);

  logic              sync_out;
  logic              p;
  btn_state_t        state;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_done;

  bit_synchronizer #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_raw),
    .q    (sync_out)
  );

  // Normalised pressed level: 1 = pressed regardless of pin polarity.
  assign p = sync_out ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      db_cnt           <= '0;
      hold_cnt         <= '0;
      long_done        <= 1'b0;
      btn_level        <= 1'b0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      busy             <= 1'b0;
    end else begin
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (p) begin
            state  <= PRESS_CHK;
            db_cnt <= '0;
            busy   <= 1'b1;
          end
        end
        PRESS_CHK: begin
          if (!p) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (db_cnt == DB_LAST) begin
            state       <= HELD;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
            busy        <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        // Every cycle spent in HELD counts toward the long press; only RELEASE_CHK freezes it.
        HELD: begin
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          if (hold_cnt == HOLD_LAST && !long_done) begin
            long_press_pulse <= 1'b1;
            long_done        <= 1'b1;
          end
          if (!p) begin
            state  <= RELEASE_CHK;
            db_cnt <= '0;
            busy   <= 1'b1;
          end
        end
        RELEASE_CHK: begin
          if (p) begin
            state <= HELD;
            busy  <= 1'b0;
          end else if (db_cnt == DB_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
            hold_cnt      <= '0;
            busy          <= 1'b0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
